// File: rtl/instr_fetch.sv
// instr_fetch: MIPS fetch front-end; imem req/ack handshake, instruction register,
// decoded fields on a valid/ready handshake, PC sequencing with branch/jump redirect.
`default_nettype none

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  output logic [5:0]  op_code,
  output logic [5:0]  funct_field,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [5:0] OP_J = 6'b000010;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] instr_count_q, instr_count_d;

  logic [31:0] jump_target;
  logic [31:0] branch_target;

  assign jump_target   = {pc_plus4_q[31:28], ir_q[25:0], 2'b00};
  assign branch_target = pc_plus4_q + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    pc_plus4_d    = pc_plus4_q;
    instr_count_d = instr_count_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          ir_d       = imem_rdata;
          pc_plus4_d = pc_q + 32'd4;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          instr_count_d = instr_count_q + 32'd1;
          state_d       = FETCH;
          if (ir_q[31:26] == OP_J) begin
            pc_d = jump_target;
          end else if (branch_taken) begin
            pc_d = branch_target;
          end else begin
            pc_d = pc_plus4_q;
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      ir_q          <= 32'd0;
      pc_plus4_q    <= 32'd0;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      pc_plus4_q    <= pc_plus4_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Gated by rst_n so an in-flight request is withdrawn the moment reset asserts.
  assign imem_req    = rst_n && (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);

  assign op_code     = ir_q[31:26];
  assign rs          = ir_q[25:21];
  assign rt          = ir_q[20:16];
  assign rd          = ir_q[15:11];
  assign imm         = ir_q[15:0];
  assign funct_field = ir_q[5:0];
  assign pc_plus4    = pc_plus4_q;
  assign instr_count = instr_count_q;

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch front-end for the single-issue MIPS core. It runs a request/acknowledge handshake with instruction memory and holds the fetched word in an instruction register. It presents the decoded fields (`op_code`, `funct_field`, register indices, immediate) to the control and decode logic through a valid/ready handshake. It owns the PC: sequential increment, taken-branch redirect and J-type jump redirect.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.

Ports (clock and reset first):
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `imem_req` output 1: fetch request to instruction memory.
- `imem_addr` output 32: fetch address, equals current PC.
- `imem_ack` input 1: memory has returned data on `imem_rdata` this cycle.
- `imem_rdata` input 32: instruction word.
- `instr_valid` output 1: instruction register holds an instruction not yet consumed.
- `instr_ready` input 1: downstream consumes the instruction this cycle.
- `branch_taken` input 1: the instruction being consumed is a branch resolved taken (Branch & Zero).
- `op_code` output 6: IR[31:26].
- `funct_field` output 6: IR[5:0].
- `rs`, `rt`, `rd` output 5 each: IR[25:21], IR[20:16], IR[15:11].
- `imm` output 16: IR[15:0].
- `pc_plus4` output 32: address of the held instruction + 4.
- `instr_count` output 32: number of instructions consumed.

## Operation

- FSM with states FETCH and HOLD.
- FETCH:
  - `imem_req`=1 and `imem_addr`=PC, both driven combinationally from state and PC.
  - Address is stable until ack.
  - On `imem_ack`: IR <= `imem_rdata`, `pc_plus4` <= PC+4, go to HOLD.
- HOLD:
  - `imem_req`=0 and `instr_valid`=1; IR and all field outputs are held stable.
  - On `instr_valid && instr_ready`: `instr_count` increments and the FSM goes to FETCH with the next PC chosen by priority:
    1. `op_code`==6'b000010 (j): PC <= {pc_plus4[31:28], IR[25:0], 2'b00}.
    2. `branch_taken`=1: PC <= pc_plus4 + (sign_extend(imm) << 2), modulo 2^32.
    3. Otherwise: PC <= pc_plus4.
- `branch_taken` is ignored unless consumption occurs that cycle.
- `imem_ack` is ignored in HOLD (no request outstanding).
- `instr_ready` is ignored in FETCH.
- PC arithmetic is 32-bit and wraps: PC 32'hFFFF_FFFC + 4 = 0.
- `instr_count` wraps from 32'hFFFF_FFFF to 0.
- Reset mid-fetch: the outstanding request is abandoned (`imem_req` drops immediately). Memory must tolerate a withdrawn request.

## Timing

- During reset and at reset values:
  - state=FETCH, PC=`RESET_PC`.
  - `imem_req`=0, forced low while `rst_n`=0.
  - `instr_valid`=0, IR=0 (so all fields are 0), `pc_plus4`=0, `instr_count`=0.
- First cycle after `rst_n` deasserts: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Ack in cycle N: `instr_valid`=1 with fields valid in cycle N+1.
- Consume in cycle M: `imem_req`=1 with the new address in cycle M+1.
- Peak throughput with zero-wait memory (ack in the request cycle) and `instr_ready` tied high: one instruction per 2 cycles.
- Memory wait states stretch FETCH indefinitely; downstream stalls stretch HOLD indefinitely. No timeout.

## Test plan

- Reset and first fetch: `RESET_PC`=0. Release reset → `imem_req`=1, `imem_addr`=0 next cycle. Pulse `rst_n` low mid-FETCH → `imem_req`=0 immediately and all outputs return to reset values.
- Sequential R-type: word 32'h0022_1820 acked at 0 → `op_code`=0, `funct_field`=6'h20, `rs`=1, `rt`=2, `rd`=3, `pc_plus4`=4. Consume → next `imem_addr`=4, `instr_count`=1.
- Stall/wait: hold `instr_ready`=0 for 5 cycles → fields unchanged, `imem_req`=0, `instr_count` unchanged. Delay `imem_ack` 3 cycles → `imem_addr` stable throughout.
- Taken branch: beq 32'h1022_FFFF at address 8, consumed with `branch_taken`=1 → next `imem_addr`=8. Same instruction with `branch_taken`=0 → next `imem_addr`=32'hC.
- Jump beats branch: j 32'h0800_0010 at address 4, consumed with `branch_taken`=1 → next `imem_addr`=32'h40.
- Wrap: `RESET_PC`=32'hFFFF_FFFC, nop fetched and consumed → `pc_plus4`=0, next `imem_addr`=0. Preload or force `instr_count`=32'hFFFF_FFFF, consume → `instr_count`=0.
